// File: rtl/npu_host_master.sv
// npu_host_master
// Bus initiator for the NPU host port. It takes one command at a time and
// turns it into host-port traffic: a single write, a single read, or a
// polled read that repeats until a masked compare matches or the attempt
// limit is reached. Every accepted command produces exactly one response.
//
// Ports
//   clk, rst_ni          clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_op 00 WRITE 01 READ 10 POLL 11 NOP
//   cmd_addr/data/mask   address, write data or compare value, compare mask
//   rsp_valid/rsp_ready  response handshake
//   rsp_data/rsp_status  read/poll data (0 for WRITE/NOP), 00 OK / 01 TIMEOUT
//   busy                 high whenever the FSM is not idle
//   ena/wea/addra/dina   registered host-port outputs
//   douta                host-port read data, valid READ_LAT cycles after issue
module npu_host_master #(
  parameter int READ_LAT = 1,
  parameter int POLL_GAP = 2,
  parameter int POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic        ena,
  output logic        wea,
  output logic [15:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta
);

  localparam int AW = $clog2(POLL_MAX + 1);
  localparam int CW = $clog2(READ_LAT + POLL_GAP + 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_TOUT  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_ISSUE, S_RD_WAIT, S_GAP, S_RESP
  } state_t;

  state_t        r_state, w_state_next;
  logic [1:0]    r_op;
  logic [15:0]   r_addr;
  logic [31:0]   r_data, r_mask;
  logic [AW-1:0] r_attempts;
  logic [CW-1:0] r_cnt;

  logic          r_ena, r_wea, r_rsp_valid;
  logic [15:0]   r_addra;
  logic [31:0]   r_dina, r_rsp_data;
  logic [1:0]    r_rsp_status;

  logic          w_ena_next, w_wea_next, w_rsp_valid_next;
  logic [15:0]   w_addra_next;
  logic [31:0]   w_dina_next, w_rsp_data_next;
  logic [1:0]    w_rsp_status_next;

  logic w_accept, w_wait_last, w_gap_done, w_match, w_limit, w_timeout;

  assign cmd_ready = rst_ni && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  // r_cnt restarts at 0 on every state change, so it counts cycles spent
  // in the current RD_WAIT or GAP stretch.
  assign w_wait_last = (r_state == S_RD_WAIT) && (r_cnt == CW'(READ_LAT - 1));
  assign w_gap_done  = (r_cnt == CW'(POLL_GAP - 1));
  assign w_match     = ((douta & r_mask) == (r_data & r_mask));
  // r_attempts has already been bumped for the read being completed.
  assign w_limit     = (r_attempts == AW'(POLL_MAX));
  assign w_timeout   = w_wait_last && (r_op == OP_POLL) && !w_match && w_limit;

  // State register and output registers
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_op         <= OP_WRITE;
      r_addr       <= '0;
      r_data       <= '0;
      r_mask       <= '0;
      r_attempts   <= '0;
      r_cnt        <= '0;
      r_ena        <= 1'b0;
      r_wea        <= 1'b0;
      r_addra      <= '0;
      r_dina       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= ST_OK;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_addr <= cmd_addr;
        r_data <= cmd_data;
        r_mask <= cmd_mask;
      end
      if (w_accept)
        r_attempts <= '0;
      else if (r_state == S_RD_ISSUE)
        r_attempts <= r_attempts + 1'b1;
      if (w_state_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_RD_WAIT || r_state == S_GAP)
        r_cnt <= r_cnt + 1'b1;
      r_ena        <= w_ena_next;
      r_wea        <= w_wea_next;
      r_addra      <= w_addra_next;
      r_dina       <= w_dina_next;
      r_rsp_valid  <= w_rsp_valid_next;
      r_rsp_data   <= w_rsp_data_next;
      r_rsp_status <= w_rsp_status_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_WRITE: w_state_next = S_WR;
            OP_READ,
            OP_POLL:  w_state_next = S_RD_ISSUE;
            default:  w_state_next = S_RESP;
          endcase
        end
      end
      S_WR:       w_state_next = S_RESP;
      S_RD_ISSUE: w_state_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (w_wait_last) begin
          if (r_op != OP_POLL || w_match || w_limit)
            w_state_next = S_RESP;
          else if (POLL_GAP == 0)
            w_state_next = S_RD_ISSUE;
          else
            w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_gap_done)
          w_state_next = S_RD_ISSUE;
      end
      S_RESP: begin
        if (rsp_ready)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: bus and response values are computed from the state being
  // entered so that they appear registered in the very cycle of that state.
  always_comb begin
    w_ena_next        = (w_state_next == S_WR) || (w_state_next == S_RD_ISSUE);
    w_wea_next        = (w_state_next == S_WR);
    w_addra_next      = r_addra;
    w_dina_next       = r_dina;
    w_rsp_valid_next  = (w_state_next == S_RESP);
    w_rsp_data_next   = r_rsp_data;
    w_rsp_status_next = r_rsp_status;
    // The first issue of a command leaves IDLE, where only cmd_addr is current.
    if (w_ena_next)
      w_addra_next = (r_state == S_IDLE) ? cmd_addr : r_addr;
    if (w_state_next == S_WR)
      w_dina_next = cmd_data;
    if (w_accept)
      w_rsp_data_next = '0;
    else if (w_wait_last)
      w_rsp_data_next = douta;
    if (r_state != S_RESP && w_state_next == S_RESP)
      w_rsp_status_next = w_timeout ? ST_TOUT : ST_OK;
  end

  assign ena        = r_ena;
  assign wea        = r_wea;
  assign addra      = r_addra;
  assign dina       = r_dina;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;

endmodule
